// File: rtl/spi_ram_burst.sv
// spi_ram_burst: opcode-driven RAM behind an SPI slave, with burst auto-increment and command sequencing
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   rx_valid, din    command word: din[MEM_WIDTH+1:MEM_WIDTH] opcode, din[MEM_WIDTH-1:0] payload
//   dout, tx_valid   registered read data and its one-cycle valid pulse
//   seq_err          one-cycle pulse: data command not allowed in the current state
//   addr_err         one-cycle pulse: address payload outside the memory
module spi_ram_burst #(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = $clog2(MEM_DEPTH),
    parameter int AUTO_INC  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_valid,
    input  logic [MEM_WIDTH+1:0] din,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 seq_err,
    output logic                 addr_err
);
    typedef enum logic [1:0] {IDLE, WR_ARMED, RD_ARMED} state_t;
    // one spare bit so MEM_DEPTH itself is representable when it equals 2**MEM_WIDTH
    localparam logic [MEM_WIDTH:0]   DEPTH_W = (MEM_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE-1:0] LAST    = ADDR_SIZE'(MEM_DEPTH - 1);
    logic [MEM_WIDTH-1:0] mem [MEM_DEPTH];
    state_t               state;
    logic [ADDR_SIZE-1:0] addr_wr, addr_rd, next_wr, next_rd;
    logic [1:0]           op;
    logic [MEM_WIDTH-1:0] payload;
    logic                 addr_ok, wr_en;
    always_comb begin
        op      = din[MEM_WIDTH+1:MEM_WIDTH];
        payload = din[MEM_WIDTH-1:0];
        // a full-width compare also rejects any set bit above the address field
        addr_ok = {1'b0, payload} < DEPTH_W;
        next_wr = AUTO_INC == 0 ? addr_wr : (addr_wr == LAST ? '0 : addr_wr + 1'b1);
        next_rd = AUTO_INC == 0 ? addr_rd : (addr_rd == LAST ? '0 : addr_rd + 1'b1);
        wr_en   = !rst && rx_valid && op == 2'b01 && state == WR_ARMED;
    end
    // memory is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr_wr] <= payload;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr_wr  <= '0;
            addr_rd  <= '0;
            dout     <= '0;
            tx_valid <= 1'b0;
            seq_err  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            seq_err  <= 1'b0;
            addr_err <= 1'b0;
            if (rx_valid) begin
                case (op)
                    2'b00: begin
                        if (addr_ok) begin
                            addr_wr <= payload[ADDR_SIZE-1:0];
                            state   <= WR_ARMED;
                        end else addr_err <= 1'b1;
                    end
                    2'b01: begin
                        if (state == WR_ARMED) addr_wr <= next_wr;
                        else seq_err <= 1'b1;
                    end
                    2'b10: begin
                        if (addr_ok) begin
                            addr_rd <= payload[ADDR_SIZE-1:0];
                            state   <= RD_ARMED;
                        end else addr_err <= 1'b1;
                    end
                    default: begin
                        if (state == RD_ARMED) begin
                            dout     <= mem[addr_rd];
                            tx_valid <= 1'b1;
                            addr_rd  <= next_rd;
                        end else seq_err <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
